// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: valid/ready register chain with bubble squeezing, flush and occupancy count.
// Define PIPE_REG_CHAIN_SKID_EN for a registered in_ready backed by a one-entry skid buffer.
module pipe_reg_chain #(
    parameter int               WIDTH     = 32,
    parameter int               STAGES    = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          flush,
    output logic [$clog2(STAGES+2)-1:0]   count
);
    localparam int CW = $clog2(STAGES+2);

    logic [STAGES-1:0] v_q, v_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES:0]   go;
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0]  src_data [STAGES];
    logic              accept, s0_v, skid_occ;
    logic [WIDTH-1:0]  s0_data;

    assign accept    = in_valid & in_ready;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    // go[k]: stage k may load this cycle (empty, or its beat moves on)
    always_comb begin
        go[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) go[k] = !v_q[k] | go[k+1];
    end

    always_comb begin
        src_v[0]    = s0_v;
        src_data[0] = s0_data;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]    = v_q[k-1];
            src_data[k] = data_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            v_d[k]    = flush ? 1'b0 : go[k] ? src_v[k] : v_q[k];
            data_d[k] = flush ? RESET_VAL : (go[k] & src_v[k]) ? src_data[k] : data_q[k];
        end
    end

    always_comb begin
        count = CW'(skid_occ);
        for (int k = 0; k < STAGES; k++) count = count + CW'(v_q[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) data_q[k] <= RESET_VAL;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

`ifdef PIPE_REG_CHAIN_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // in_ready depends only on the skid flop, never on out_ready
    assign in_ready    = !rst & !flush & !skid_v_q;
    assign s0_v        = skid_v_q | accept;
    assign s0_data     = skid_v_q ? skid_data_q : in_data;
    assign skid_occ    = skid_v_q;
    assign skid_v_d    = flush ? 1'b0 : skid_v_q ? !go[0] : accept & !go[0];
    assign skid_data_d = flush ? RESET_VAL : (accept & !go[0]) ? in_data : skid_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_v_q    <= 1'b0;
            skid_data_q <= RESET_VAL;
        end else begin
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    assign in_ready = !rst & !flush & go[0];
    assign s0_v     = accept;
    assign s0_data  = in_data;
    assign skid_occ = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed and scoreboarded checks of pipe_reg_chain (WIDTH=32, STAGES=3).
module tb_pipe_reg_chain;
`ifdef PIPE_REG_CHAIN_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] in_data, out_data;
    logic [2:0]  count;
    int          checks = 0;
    int          fails  = 0;

    pipe_reg_chain #(.WIDTH(32), .STAGES(3), .RESET_VAL(32'h0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_in_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++; if (count !== ((c <= 3) ? 3'd1 : 3'd0)) begin fails++; $display("FAIL single_count c%0d got %0d want %0d", c, count, (c <= 3) ? 1 : 0); end
            checks++; if (out_valid !== (c == 3)) begin fails++; $display("FAIL single_out_valid c%0d got %0b want %0b", c, out_valid, c == 3); end
            if (c == 3) begin
                checks++; if (out_data !== 32'hA5A5_0001) begin fails++; $display("FAIL single_out_data got %h want a5a50001", out_data); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            in_valid = (c < 8);
            in_data  = 32'(c + 1);
            #1;
            if (c < 8) begin
                checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready c%0d got %0b want 1", c, in_ready); end
            end
            checks++; if (out_valid !== (c >= 3)) begin fails++; $display("FAIL b2b_out_valid c%0d got %0b want %0b", c, out_valid, c >= 3); end
            if (c >= 3) begin
                checks++; if (out_data !== 32'(c - 2)) begin fails++; $display("FAIL b2b_out_data c%0d got %h want %h", c, out_data, 32'(c - 2)); end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_drained_count got %0d want 0", count); end
        tick();
    endtask

    task automatic test_squeeze();
        int n;
        n = 3 + SKID;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i + 1);
            #1;
            checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL squeeze_in_ready i%0d got %0b want 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b1;
        in_data  = 32'h4;
        #1;
        checks++; if (count !== 3'd3) begin fails++; $display("FAIL squeeze_count3 got %0d want 3", count); end
        checks++; if (in_ready !== 1'(SKID)) begin fails++; $display("FAIL squeeze_in_ready_full got %0b want %0d", in_ready, SKID); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'(n)) begin fails++; $display("FAIL squeeze_count_full got %0d want %0d", count, n); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL squeeze_in_ready_stall got %0b want 0", in_ready); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin fails++; $display("FAIL squeeze_stall_hold got v%0b %h want v1 00000001", out_valid, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 32'(i + 1)) begin fails++; $display("FAIL squeeze_drain i%0d got v%0b %h want v1 %h", i, out_valid, out_data, 32'(i + 1)); end
            tick();
        end
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL squeeze_empty got v%0b c%0d want v0 c0", out_valid, count); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3 + SKID; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(16 + i);
            #1;
            checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_fill_in_ready i%0d got %0b want 1", i, in_ready); end
            tick();
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h99;
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL flush_count got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL flush_out_data got %h want 0", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL flush_no_accept got v%0b c%0d want v0 c0", out_valid, count); end
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(32 + i);
            tick();
        end
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got %0b want 0", out_valid); end
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL rstmid_count got %0d want 0", count); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_in_ready got %0b want 0", in_ready); end
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h55;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_release_in_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (out_valid !== (c == 3)) begin fails++; $display("FAIL rstmid_out_valid c%0d got %0b want %0b", c, out_valid, c == 3); end
            if (c == 3) begin
                checks++; if (out_data !== 32'h55) begin fails++; $display("FAIL rstmid_out_data got %h want 55", out_data); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        for (int c = 0; c < 10010; c++) begin
            in_valid  = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = (c < 10000) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data   = $urandom;
            #1;
            checks++; if (int'(count) !== q.size()) begin fails++; $display("FAIL rand_count c%0d got %0d want %0d", c, count, q.size()); end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin fails++; $display("FAIL rand_extra_beat c%0d got %h want none", c, out_data); end
                else begin
                    if (out_data !== q[0]) begin fails++; $display("FAIL rand_order c%0d got %h want %h", c, out_data, q[0]); end
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
            tick();
        end
        checks++; if (q.size() != 0) begin fails++; $display("FAIL rand_lost_beats got %0d left want 0", q.size()); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_squeeze();
        test_flush();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 32, payload bits per stage.
REQ-002 Parameter STAGES, default 3, register stages in the chain; legal range 1..8.
REQ-003 Parameter RESET_VAL, default 0 (WIDTH bits), value loaded into every data register on reset and flush.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  upstream beat present.
REQ-007 in_ready  out  1  chain accepts a beat this cycle.
REQ-008 in_data  in  WIDTH  upstream payload.
REQ-009 out_valid  out  1  last stage holds a beat.
REQ-010 out_ready  in  1  downstream accepts the beat.
REQ-011 out_data  out  WIDTH  last-stage payload.
REQ-012 flush  in  1  synchronous squash of all in-flight beats.
REQ-013 count  out  CW = $clog2(STAGES+2)  number of valid beats held, including the skid entry.

Function
REQ-014 Each stage k SHALL hold data[k] and valid v[k]; stage 0 is nearest input; out_data = data[STAGES-1], out_valid = v[STAGES-1].
REQ-015 Stage k SHALL advance when v[k]=1 and (k = last ? out_ready : !v[k+1] or stage k+1 advances); the output accepts on out_valid & out_ready.
REQ-016 Stage k SHALL load from stage k-1 (or input for k=0) when it is empty or advancing; it sets v[k] to the source valid and holds otherwise (stall: data and valid unchanged).
REQ-017 Empty stages SHALL collapse (bubble squeezing): a beat moves forward one stage per cycle while the next stage is empty, even if out_ready=0.
REQ-018 Latency from input accept to out_valid on an empty chain SHALL be exactly STAGES cycles.
REQ-019 Throughput SHALL be one beat per cycle when out_ready is held 1.
REQ-020 Beats SHALL leave in the order accepted; none duplicated or dropped except by flush.
REQ-021 flush=1 SHALL clear every valid bit (including skid) and load RESET_VAL into data at the next edge; in_ready SHALL be 0 while flush=1, and no input beat is accepted that cycle.
REQ-022 flush has priority over simultaneous in_valid and out_ready; an output handshake coinciding with flush still counts as delivered.
REQ-023 count SHALL equal the sum of valid bits, updated with them; maximum STAGES (+1 with skid).

Reset
REQ-024 On rst=1, all v[k]=0, all data[k]=RESET_VAL, skid empty, count=0, out_valid=0, immediately and without a clock edge.
REQ-025 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts.
REQ-026 Reset asserted mid-transfer SHALL discard all in-flight beats; no partial beat appears after release.

Configuration
REQ-027 Macro PIPE_REG_CHAIN_SKID_EN selects input-ready registration.
REQ-028 Without the macro: in_ready = !flush & (!v[0] | stage 0 advances), combinational through the chain from out_ready.
REQ-029 With the macro: in_ready SHALL be driven directly by a flop (= skid entry empty); a one-entry skid buffer ahead of stage 0 captures a beat accepted while stage 0 stalls; stage 0 loads from skid before in_data; latency increases by 0 when skid is empty; no path exists from out_ready to in_ready.
REQ-030 With the macro, count maximum is STAGES+1 and skid content obeys REQ-021 and REQ-024.

Verification
REQ-031 WIDTH=32, STAGES=3, out_ready=1, push 0xA5A5_0001 at cycle 0 -> out_valid=1, out_data=0xA5A5_0001 at cycle 3, count 1 during cycles 1-3.
REQ-032 Stream 0x1..0x8 back-to-back with out_ready=1 -> outputs 0x1..0x8 on consecutive cycles starting cycle 3, in_ready never 0.
REQ-033 out_ready=0, push 0x1,0x2,0x3 -> beats squeeze, count=3, in_ready=0 (no skid) or 1 once more then 0 with skid, count=4; release out_ready -> 0x1,0x2,0x3(,0x4) in order.
REQ-034 Chain full, assert flush for one cycle with in_valid=1 -> next cycle count=0, out_valid=0, out_data=RESET_VAL, incoming beat not accepted.
REQ-035 Assert rst mid-stream between edges -> out_valid and count drop to 0 immediately; after release, in_ready=1 and a new beat 0x55 emerges after STAGES cycles.
REQ-036 Random in_valid/out_ready (≥10k cycles, STAGES=1 and 8) -> scoreboard confirms order and no loss; with skid, in_ready never changes combinationally with out_ready.
